// File: rtl/forno_game.sv
// Reaction game: lights one of seven LEDs chosen by an LFSR and scores the
// player's first new button press inside a response window, over RODADAS rounds.
module forno_game #(
    parameter int         RODADAS        = 7,
    parameter int         JANELA_FACIL   = 1000,
    parameter int         JANELA_DIFICIL = 500,
    parameter int         PAUSA          = 200,
    parameter logic [7:0] SEMENTE        = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       dificuldade,
    input  logic [6:0] botoes,
    output logic [3:0] estado,
    output logic [6:0] jogadas,
    output logic [2:0] pontuacao,
    output logic       pronto
);

    localparam logic [3:0] S_INICIAL = 4'b0000;
    localparam logic [3:0] S_PREPARA = 4'b0010;
    localparam logic [3:0] S_SORTEIA = 4'b0011;
    localparam logic [3:0] S_ESPERA  = 4'b0100;
    localparam logic [3:0] S_ACERTO  = 4'b0101;
    localparam logic [3:0] S_ERRO    = 4'b0110;
    localparam logic [3:0] S_PROXIMA = 4'b0111;
    localparam logic [3:0] S_FIM     = 4'b1111;

    // One counter serves both the response window and the feedback pause.
    localparam int MAX_JANELA = (JANELA_FACIL > JANELA_DIFICIL) ? JANELA_FACIL : JANELA_DIFICIL;
    localparam int MAX_CONTA  = (MAX_JANELA > PAUSA) ? MAX_JANELA : PAUSA;
    localparam int CW         = $clog2(MAX_CONTA + 1);

    localparam logic [CW-1:0] LIMITE_FACIL   = CW'(JANELA_FACIL - 1);
    localparam logic [CW-1:0] LIMITE_DIFICIL = CW'(JANELA_DIFICIL - 1);
    localparam logic [CW-1:0] LIMITE_PAUSA   = CW'(PAUSA - 1);
    localparam logic [2:0]    TOTAL_RODADAS  = 3'(RODADAS);

    logic [3:0]    estado_q, estado_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [6:0]    botoes_q, botoes_d;
    logic [2:0]    alvo_q, alvo_d;
    logic [2:0]    pontuacao_q, pontuacao_d;
    logic [2:0]    rodada_q, rodada_d;
    logic          dif_q, dif_d;
    logic [CW-1:0] conta_q, conta_d;

    logic          press;
    logic          timeout;
    logic          pausa_fim;
    logic [6:0]    alvo_oh;
    logic [2:0]    sorteio;
    logic [2:0]    rodada_inc;

    always_comb begin
        alvo_oh    = 7'b0000001 << alvo_q;
        press      = |(botoes & ~botoes_q);
        timeout    = (conta_q == (dif_q ? LIMITE_DIFICIL : LIMITE_FACIL));
        pausa_fim  = (conta_q == LIMITE_PAUSA);
        sorteio    = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
        rodada_inc = rodada_q + 3'd1;
    end

    always_comb begin
        estado_d    = estado_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        botoes_d    = botoes;
        alvo_d      = alvo_q;
        pontuacao_d = pontuacao_q;
        rodada_d    = rodada_q;
        dif_d       = dif_q;
        conta_d     = conta_q + CW'(1);

        case (estado_q)
            S_INICIAL, S_FIM: begin
                if (jogar) estado_d = S_PREPARA;
            end
            S_PREPARA: begin
                pontuacao_d = 3'd0;
                rodada_d    = 3'd0;
                dif_d       = dificuldade;
                estado_d    = S_SORTEIA;
            end
            S_SORTEIA: begin
                alvo_d   = sorteio;
                conta_d  = '0;
                estado_d = S_ESPERA;
            end
            S_ESPERA: begin
                // A press in the last window cycle wins over the timeout.
                if (press) begin
                    conta_d = '0;
                    if (botoes == alvo_oh) begin
                        estado_d    = S_ACERTO;
                        pontuacao_d = (pontuacao_q == 3'd7) ? 3'd7 : pontuacao_q + 3'd1;
                    end else begin
                        estado_d = S_ERRO;
                    end
                end else if (timeout) begin
                    conta_d  = '0;
                    estado_d = S_ERRO;
                end
            end
            S_ACERTO, S_ERRO: begin
                if (pausa_fim) estado_d = S_PROXIMA;
            end
            S_PROXIMA: begin
                rodada_d = rodada_inc;
                estado_d = (rodada_inc == TOTAL_RODADAS) ? S_FIM : S_SORTEIA;
            end
            default: estado_d = S_INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= S_INICIAL;
            lfsr_q      <= SEMENTE;
            botoes_q    <= 7'h00;
            alvo_q      <= 3'd0;
            pontuacao_q <= 3'd0;
            rodada_q    <= 3'd0;
            dif_q       <= 1'b0;
            conta_q     <= '0;
        end else begin
            estado_q    <= estado_d;
            lfsr_q      <= lfsr_d;
            botoes_q    <= botoes_d;
            alvo_q      <= alvo_d;
            pontuacao_q <= pontuacao_d;
            rodada_q    <= rodada_d;
            dif_q       <= dif_d;
            conta_q     <= conta_d;
        end
    end

    always_comb begin
        case (estado_q)
            S_ESPERA: jogadas = alvo_oh;
            S_ACERTO: jogadas = 7'h7F;
            default:  jogadas = 7'h00;
        endcase
    end

    assign estado    = estado_q;
    assign pontuacao = pontuacao_q;
    assign pronto    = (estado_q == S_FIM);

endmodule

// File: tb/tb_forno_game.sv
// Randomized bench for forno_game: a round-level game model predicts each
// round's target, outcome, timing and score, and every output is compared against it.
module tb_forno_game;

    localparam int         P_RODADAS = 7;
    localparam int         P_PAUSA   = 4;
    localparam int         P_JF      = 12;
    localparam int         P_JD      = 8;
    localparam logic [7:0] P_SEMENTE = 8'hA5;

    localparam logic [3:0] S_INICIAL = 4'b0000;
    localparam logic [3:0] S_PREPARA = 4'b0010;
    localparam logic [3:0] S_SORTEIA = 4'b0011;
    localparam logic [3:0] S_ESPERA  = 4'b0100;
    localparam logic [3:0] S_ACERTO  = 4'b0101;
    localparam logic [3:0] S_ERRO    = 4'b0110;
    localparam logic [3:0] S_PROXIMA = 4'b0111;
    localparam logic [3:0] S_FIM     = 4'b1111;

    localparam int A_CORRECT = 0;
    localparam int A_WRONG   = 1;
    localparam int A_MULTI   = 2;
    localparam int A_TIMEOUT = 3;
    localparam int A_NONE    = 4;
    localparam int A_HELD    = 5;

    localparam int M_ALL_OK = 0;
    localparam int M_NONE   = 1;
    localparam int M_SCRIPT = 2;
    localparam int M_RANDOM = 3;

    logic       clock;
    logic       reset;
    logic       jogar;
    logic       dificuldade;
    logic [6:0] botoes;
    logic [3:0] estado;
    logic [6:0] jogadas;
    logic [2:0] pontuacao;
    logic       pronto;

    int         n_checks;
    int         n_errors;
    int         score;
    logic [7:0] ref_lfsr;
    logic [3:0] exp_q[$];

    forno_game #(
        .RODADAS       (P_RODADAS),
        .JANELA_FACIL  (P_JF),
        .JANELA_DIFICIL(P_JD),
        .PAUSA         (P_PAUSA),
        .SEMENTE       (P_SEMENTE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .jogar      (jogar),
        .dificuldade(dificuldade),
        .botoes     (botoes),
        .estado     (estado),
        .jogadas    (jogadas),
        .pontuacao  (pontuacao),
        .pronto     (pronto)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference sequence x^8+x^6+x^5+x^4+1: feedback is the parity of bits 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) ref_lfsr <= P_SEMENTE;
        else       ref_lfsr <= lfsr_next(ref_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Starts at the negedge of a SORTEIA cycle, ends at the negedge of PROXIMA.
    task automatic play_round(input int action, input int win);
        logic [2:0] alvo;
        logic [6:0] oh;
        logic [6:0] other;
        logic [6:0] pat;
        int         d;
        check("sorteia", 32'(estado), 32'(S_SORTEIA));
        alvo  = (ref_lfsr[2:0] == 3'd7) ? 3'd0 : ref_lfsr[2:0];
        oh    = 7'd1 << alvo;
        other = 7'd1 << ((int'(alvo) + 1 + int'($urandom_range(0, 5))) % 7);
        botoes = (action == A_HELD) ? oh : 7'h00;
        d = (action == A_TIMEOUT) ? win - 1 : int'($urandom_range(0, win - 1));
        step();
        check("espera_entry", 32'(estado), 32'(S_ESPERA));
        check("jogadas_alvo", 32'(jogadas), 32'(oh));
        check("pronto_jogo", 32'(pronto), 32'(0));
        if (action == A_NONE || action == A_HELD) begin
            for (int i = 1; i < win; i++) begin
                jogar = 1'($urandom_range(0, 1));
                step();
                check("espera_janela", 32'(estado), 32'(S_ESPERA));
            end
            exp_q.push_back(S_ERRO);
        end else begin
            for (int i = 0; i < d; i++) begin
                jogar = 1'($urandom_range(0, 1));
                step();
                check("espera_antes", 32'(estado), 32'(S_ESPERA));
            end
            case (action)
                A_WRONG: pat = other;
                A_MULTI: pat = oh | other;
                default: pat = oh;
            endcase
            botoes = pat;
            if (pat == oh) begin
                exp_q.push_back(S_ACERTO);
                if (score < 7) score++;
            end else begin
                exp_q.push_back(S_ERRO);
            end
        end
        jogar = 1'b0;
        step();
        check("resultado", 32'(estado), 32'(exp_q[0]));
        check("jogadas_res", 32'(jogadas), (exp_q[0] == S_ACERTO) ? 32'h7F : 32'h0);
        check("score_res", 32'(pontuacao), 32'(score));
        // Buttons and jogar during the feedback pause must be ignored.
        for (int p = 1; p < P_PAUSA; p++) begin
            botoes = 7'($urandom_range(0, 127));
            jogar  = 1'($urandom_range(0, 1));
            step();
            check("pausa", 32'(estado), 32'(exp_q[0]));
            check("score_pausa", 32'(pontuacao), 32'(score));
        end
        void'(exp_q.pop_front());
        botoes = 7'h00;
        jogar  = 1'b0;
        step();
        check("proxima", 32'(estado), 32'(S_PROXIMA));
    endtask

    function automatic int pick_action(input int mode, input int r);
        int script[7] = '{A_WRONG, A_MULTI, A_TIMEOUT, A_HELD, A_CORRECT, A_NONE, A_TIMEOUT};
        case (mode)
            M_ALL_OK: return A_CORRECT;
            M_NONE:   return A_NONE;
            M_SCRIPT: return script[r];
            default:  return int'($urandom_range(0, 5));
        endcase
    endfunction

    // Starts at a negedge in INICIAL or FIM; ends in FIM, or in ESPERA of the
    // round after stop_after when stop_after is nonzero.
    task automatic play_game(input logic dif, input int mode, input int stop_after);
        int win;
        win         = dif ? P_JD : P_JF;
        score       = 0;
        dificuldade = dif;
        jogar       = 1'b1;
        step();
        jogar = 1'b0;
        check("prepara", 32'(estado), 32'(S_PREPARA));
        step();
        dificuldade = ~dif;
        check("score_clear", 32'(pontuacao), 32'(0));
        for (int r = 0; r < P_RODADAS; r++) begin
            play_round(pick_action(mode, r), win);
            step();
            if (r == P_RODADAS - 1) begin
                check("fim", 32'(estado), 32'(S_FIM));
                check("pronto_fim", 32'(pronto), 32'(1));
                check("score_fim", 32'(pontuacao), 32'(score));
                check("jogadas_fim", 32'(jogadas), 32'(0));
            end else if (stop_after != 0 && r + 1 == stop_after) begin
                check("sorteia_stop", 32'(estado), 32'(S_SORTEIA));
                step();
                check("espera_stop", 32'(estado), 32'(S_ESPERA));
                return;
            end
        end
    endtask

    task automatic fim_idle(input int n);
        for (int i = 0; i < n; i++) begin
            botoes = 7'($urandom_range(0, 127));
            step();
            check("fim_hold", 32'(estado), 32'(S_FIM));
            check("fim_score", 32'(pontuacao), 32'(score));
        end
        botoes = 7'h00;
        step();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        score       = 0;
        reset       = 1'b0;
        jogar       = 1'b0;
        dificuldade = 1'b0;
        botoes      = 7'h00;
        #1 reset = 1'b1;
        #2;
        check("rst_estado", 32'(estado), 32'(S_INICIAL));
        check("rst_jogadas", 32'(jogadas), 32'(0));
        check("rst_score", 32'(pontuacao), 32'(0));
        check("rst_pronto", 32'(pronto), 32'(0));
        step();
        reset = 1'b0;
        step();
        check("inicial", 32'(estado), 32'(S_INICIAL));

        play_game(1'b0, M_ALL_OK, 0);
        check("all_ok_score", 32'(pontuacao), 32'(7));
        fim_idle(3);
        play_game(1'b1, M_NONE, 0);
        check("none_score", 32'(pontuacao), 32'(0));
        fim_idle(2);
        play_game(1'($urandom_range(0, 1)), M_SCRIPT, 0);
        fim_idle(1);

        play_game(1'b0, M_ALL_OK, 3);
        check("score_pre_reset", 32'(pontuacao), 32'(3));
        #2 reset = 1'b1;
        #1;
        check("midrst_estado", 32'(estado), 32'(S_INICIAL));
        check("midrst_score", 32'(pontuacao), 32'(0));
        check("midrst_jogadas", 32'(jogadas), 32'(0));
        check("midrst_pronto", 32'(pronto), 32'(0));
        score = 0;
        step();
        reset  = 1'b0;
        botoes = 7'h00;
        jogar  = 1'b0;
        step();
        check("inicial_pos", 32'(estado), 32'(S_INICIAL));

        play_game(1'($urandom_range(0, 1)), M_RANDOM, 0);
        fim_idle(1);
        play_game(1'($urandom_range(0, 1)), M_RANDOM, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
